// File: rtl/aidc_lite_decomp_wr_arb.sv
// Round-robin write-port arbiter for the shared decompression output buffer.
// Drives one registered buffer write port and tracks per-block written entries.
module aidc_lite_decomp_wr_arb #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          block_start_i,
  output logic                          buf_wren_o,
  output logic [ADDR_WIDTH-1:0]         buf_waddr_o,
  output logic [DATA_WIDTH-1:0]         buf_wdata_o,
  output logic [2**ADDR_WIDTH-1:0]      wr_map_o,
  output logic                          block_full_o,
  output logic                          dup_err_o,
  output logic [NUM_REQ-1:0]            dup_src_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      next_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  found;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DEPTH-1:0]      map_next;
  logic                  is_dup;

  // Base is always below NUM_REQ, so one conditional subtract implements the wrap.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && req_valid_i[wrap_idx(ptr, off)]) begin
        found     = 1'b1;
        grant_idx = wrap_idx(ptr, off);
      end
    end
    grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  assign req_ready_o = grant;
  assign accept      = found;
  assign next_ptr    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // One-hot grant selects the winning slice; data of losers never reaches the port.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A block start wipes the old map first, so an accept in the same cycle is never a duplicate.
  always_comb begin
    map_next = block_start_i ? '0 : wr_map_o;
    is_dup   = accept && !block_start_i && wr_map_o[sel_addr];
    if (accept) map_next[sel_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= next_ptr;
    end
  end

  // NOTE: the write data register is reset too, because every output must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_wren_o  <= 1'b0;
      buf_waddr_o <= '0;
      buf_wdata_o <= '0;
    end else begin
      buf_wren_o <= accept;
      if (accept) begin
        buf_waddr_o <= sel_addr;
        buf_wdata_o <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_map_o     <= '0;
      block_full_o <= 1'b0;
      dup_err_o    <= 1'b0;
      dup_src_o    <= '0;
    end else begin
      wr_map_o     <= map_next;
      block_full_o <= &map_next;
      if (block_start_i) begin
        dup_err_o <= 1'b0;
        dup_src_o <= '0;
      end else if (is_dup) begin
        dup_err_o <= 1'b1;
        if (!dup_err_o) dup_src_o <= grant;
      end
    end
  end

endmodule

// File: tb/tb_aidc_lite_decomp_wr_arb.sv
// Directed bench for the round-robin buffer write arbiter (NUM_REQ=3, 16-entry block).
module tb_aidc_lite_decomp_wr_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req_valid;
  logic [11:0]  req_addr;
  logic [191:0] req_data;
  logic [2:0]   req_ready;
  logic         block_start;
  logic         buf_wren;
  logic [3:0]   buf_waddr;
  logic [63:0]  buf_wdata;
  logic [15:0]  wr_map;
  logic         block_full;
  logic         dup_err;
  logic [2:0]   dup_src;

  int tests = 0;
  int fails = 0;

  aidc_lite_decomp_wr_arb #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .block_start_i(block_start),
    .buf_wren_o   (buf_wren),
    .buf_waddr_o  (buf_waddr),
    .buf_wdata_o  (buf_wdata),
    .wr_map_o     (wr_map),
    .block_full_o (block_full),
    .dup_err_o    (dup_err),
    .dup_src_o    (dup_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [63:0] d);
    req_valid[i]         = v;
    req_addr[i*4 +: 4]   = a;
    req_data[i*64 +: 64] = d;
  endtask

  task automatic pulse_start();
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
  endtask

  int          i0, i1;
  logic [63:0] exp_d;
  logic [3:0]  exp_a;
  int          bp_seq [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    block_start = 1'b0;
    tick();
    tick();
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_wren", 64'(buf_wren), 64'h0);
    check("rst_wdata", buf_wdata, 64'h0);
    check("rst_map", 64'(wr_map), 64'h0);
    check("rst_dup", 64'({dup_err, dup_src, block_full}), 64'h0);

    // First write after reset: requester 1, addr 3
    rst_n = 1'b1;
    set_req(1, 1'b1, 4'd3, 64'hD1D1_0000_0000_0003);
    #1;
    check("first_ready", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 4'd0, 64'h0);
    check("first_wren", 64'(buf_wren), 64'h1);
    check("first_waddr", 64'(buf_waddr), 64'h3);
    check("first_wdata", buf_wdata, 64'hD1D1_0000_0000_0003);
    check("first_map", 64'(wr_map), 64'h0008);

    // Reset in the middle of a registered write
    set_req(0, 1'b1, 4'd7, 64'h77);
    tick();
    check("mid_wren_pre", 64'(buf_wren), 64'h1);
    set_req(0, 1'b0, 4'd0, 64'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wren", 64'(buf_wren), 64'h0);
    check("mid_rst_waddr", 64'(buf_waddr), 64'h0);
    check("mid_rst_map", 64'(wr_map), 64'h0);
    rst_n = 1'b1;

    // Round-robin with all three requesters continuously valid
    set_req(0, 1'b1, 4'd0, 64'hA0A0);
    set_req(1, 1'b1, 4'd1, 64'hA1A1);
    set_req(2, 1'b1, 4'd2, 64'hA2A2);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      check($sformatf("rr_wren_%0d", k), 64'(buf_wren), 64'h1);
      exp_d = (k % 3 == 0) ? 64'hA0A0 : (k % 3 == 1) ? 64'hA1A1 : 64'hA2A2;
      check($sformatf("rr_wdata_%0d", k), buf_wdata, exp_d);
    end
    req_valid = '0;
    pulse_start();
    check("bs_clear_map", 64'(wr_map), 64'h0);
    check("bs_clear_dup", 64'(dup_err), 64'h0);

    // Back-pressure: requester 0 streams addr 0..7, requester 1 offers addr 8..11
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 12; c++) begin
      if (i0 < 8) set_req(0, 1'b1, 4'(i0), 64'h100 + 64'(i0));
      else        set_req(0, 1'b0, 4'd0, 64'h0);
      if (i1 < 4) set_req(1, 1'b1, 4'(8 + i1), 64'h200 + 64'(i1));
      else        set_req(1, 1'b0, 4'd0, 64'h0);
      #1;
      check($sformatf("bp_ready_%0d", c), 64'(req_ready), 64'(3'b001 << bp_seq[c]));
      if (bp_seq[c] == 0) begin
        exp_a = 4'(i0);
        exp_d = 64'h100 + 64'(i0);
        i0++;
      end else begin
        exp_a = 4'(8 + i1);
        exp_d = 64'h200 + 64'(i1);
        i1++;
      end
      tick();
      check($sformatf("bp_waddr_%0d", c), 64'(buf_waddr), 64'(exp_a));
      check($sformatf("bp_wdata_%0d", c), buf_wdata, exp_d);
    end
    req_valid = '0;
    #1;
    check("bp_map", 64'(wr_map), 64'h0FFF);
    check("bp_dup", 64'(dup_err), 64'h0);

    // Block full: requester 0 writes all 16 entries
    pulse_start();
    for (int a = 0; a < 16; a++) begin
      set_req(0, 1'b1, 4'(a), 64'h300 + 64'(a));
      tick();
      if (a == 14) check("full_early", 64'(block_full), 64'h0);
    end
    req_valid = '0;
    check("full_flag", 64'(block_full), 64'h1);
    check("full_map", 64'(wr_map), 64'hFFFF);
    check("full_dup", 64'(dup_err), 64'h0);

    // Write after full is a duplicate
    set_req(0, 1'b1, 4'd4, 64'h44);
    tick();
    req_valid = '0;
    check("waf_dup", 64'(dup_err), 64'h1);
    check("waf_src", 64'(dup_src), 64'b001);

    // Block start coinciding with an accept of addr 9 on a full map
    set_req(0, 1'b1, 4'd9, 64'h99);
    block_start = 1'b1;
    #1;
    check("sim_ready", 64'(req_ready), 64'b001);
    tick();
    block_start = 1'b0;
    req_valid   = '0;
    check("sim_map", 64'(wr_map), 64'h0200);
    check("sim_full", 64'(block_full), 64'h0);
    check("sim_dup", 64'(dup_err), 64'h0);
    check("sim_src", 64'(dup_src), 64'h0);

    // Duplicate chain on addr 5: requesters 1, 2, then 0
    set_req(1, 1'b1, 4'd5, 64'h51);
    #1;
    check("dup_ready1", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    check("dup_first_ok", 64'(dup_err), 64'h0);
    check("dup_map", 64'(wr_map), 64'h0220);
    set_req(2, 1'b1, 4'd5, 64'h52);
    #1;
    check("dup_ready2", 64'(req_ready), 64'b100);
    tick();
    req_valid = '0;
    check("dup_err2", 64'(dup_err), 64'h1);
    check("dup_src2", 64'(dup_src), 64'b100);
    check("dup_wdata2", buf_wdata, 64'h52);
    set_req(0, 1'b1, 4'd5, 64'h50);
    #1;
    check("dup_ready0", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("dup_err3", 64'(dup_err), 64'h1);
    check("dup_src3", 64'(dup_src), 64'b100);

    // Idle cycle: no write, address and data hold
    tick();
    check("idle_wren", 64'(buf_wren), 64'h0);
    check("idle_waddr", 64'(buf_waddr), 64'h5);
    check("idle_wdata", buf_wdata, 64'h50);

    pulse_start();
    check("clr_dup", 64'(dup_err), 64'h0);
    check("clr_src", 64'(dup_src), 64'h0);
    check("clr_map", 64'(wr_map), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aidc_lite_decomp_wr_arb.md
# aidc_lite_decomp_wr_arb

Write-port arbiter for the shared decompression output buffer. It replaces the OR-merge of decompressor write ports with a round-robin arbiter that back-pressures each decompressor through a valid/ready handshake. It drives a single registered write port into the buffer. It also keeps a per-block bitmap of written entries, which provides the block-complete status and duplicate-write detection to the decompression engine. It sits between the decompressor submodules (SR, ZRLE, and future ones) and the shared buffer.

## Interface
- NUM_REQ, 3, number of write requesters (index 0 = SR, 1 = ZRLE, 2 = spare); legal range 1..8
- ADDR_WIDTH, 4, buffer address width; the block size is 2**ADDR_WIDTH entries
- DATA_WIDTH, 64, buffer word width

- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid_i  input  NUM_REQ  per-requester write request
- req_addr_i  input  NUM_REQ*ADDR_WIDTH  per-requester address; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_i  input  NUM_REQ*DATA_WIDTH  per-requester data, sliced the same way
- req_ready_o  output  NUM_REQ  one-hot grant; the request is accepted in a cycle where valid and ready are both 1
- block_start_i  input  1  single-cycle pulse that opens a new block and clears all block status
- buf_wren_o  output  1  buffer write enable (registered)
- buf_waddr_o  output  ADDR_WIDTH  buffer write address (registered)
- buf_wdata_o  output  DATA_WIDTH  buffer write data (registered)
- wr_map_o  output  2**ADDR_WIDTH  bit k = entry k written since the last block_start_i
- block_full_o  output  1  all bits of wr_map_o are 1
- dup_err_o  output  1  sticky; an entry was written twice within one block
- dup_src_o  output  NUM_REQ  one-hot index of the requester that caused the first duplicate

## Operation
- **Reset.** All outputs are 0. The round-robin pointer is 0.
- **Arbitration.** Round-robin over the requesters with req_valid_i=1.
  - The search starts at the pointer and wraps modulo NUM_REQ.
  - The grant is combinational: req_ready_o is one-hot, or all zero when no request is valid.
  - After an accept by requester g, the pointer becomes (g+1) mod NUM_REQ. With no accept, the pointer holds.
- **Requester rules.** Once valid is raised, a requester holds valid, addr and data stable until it is accepted. Ready never depends on an unaccepted requester's data.
- **Buffer write.** An accept registers the granted addr and data into buf_waddr_o/buf_wdata_o and sets buf_wren_o=1 in the next cycle. With no accept, buf_wren_o=0 and addr/data hold their last values.
- **Throughput.** One write per cycle, sustained.
- **Block status.** On an accept, wr_map_o[addr] is set. block_full_o = &wr_map_o, registered in the same cycle as the map.
- **Duplicate detection.** If an accepted addr already has its map bit set:
  - dup_err_o is set and stays set until block_start_i or reset;
  - dup_src_o latches the one-hot requester only on the first error, and later duplicates do not change it;
  - the write is still performed.
- **block_start_i.** Clears wr_map_o, block_full_o, dup_err_o and dup_src_o.
  - If an accept occurs in the same cycle, the new block's map contains only that address.
  - The round-robin pointer is not affected.
- **Write after full.** An accept while block_full_o=1 raises dup_err_o, because the bit is already set.
- **Reset mid-operation.** Everything clears asynchronously, including any pending registered write. Requesters must re-present.
- **NUM_REQ=1.** req_ready_o = req_valid_i and the pointer stays at 0.

## Timing
- Accept to buf_wren_o: 1 cycle.
- Accept to wr_map_o, block_full_o and dup_err_o update: 1 cycle, aligned with buf_wren_o.
- block_start_i to status cleared: 1 cycle.
- Combinational path: req_valid_i → req_ready_o only. No other input-to-output combinational paths.
- Worst-case wait for a requester that holds valid: NUM_REQ-1 cycles.

## Test plan
- **Reset values.** Assert rst_n=0 mid-write → all outputs 0 asynchronously. Release, then requester 1 writes addr 3 → buf_wren_o=1, waddr=3 one cycle later.
- **Round-robin fairness.** Requesters 0, 1 and 2 valid continuously with distinct data → grant sequence 0,1,2,0,1,2. Exactly one buf write per cycle, with data matching the grantee.
- **Back-pressure stability.** Requester 0 streams addr 0..7 while requester 1 is also valid → requester 1 stalls at most 1 cycle per grant. Both streams land in full. Requester 1's addr/data are never sampled while not ready.
- **Block full.** block_start_i, then requester 0 writes addr 0..15 → block_full_o=1 one cycle after the 16th accept, wr_map_o=16'hFFFF, dup_err_o=0.
- **Duplicate error.** Requester 1 writes addr 5, then requester 2 writes addr 5, then requester 0 writes addr 5 → dup_err_o=1 and dup_src_o=3'b100, both unchanged after the third write. block_start_i clears both.
- **Simultaneous start and write.** block_start_i in the same cycle as an accept of addr 9 on a full map → next cycle wr_map_o=16'h0200, block_full_o=0, dup_err_o=0.
